// File: rtl/ls_buffer.sv
// ls_buffer: in-order circular queue of load/store instructions sitting
// between the dispatcher and alu_ls.
//   - Dispatch (DP_*) writes one entry at tail per cycle. An operand that is
//     not ready at dispatch may be captured in the same cycle from either
//     broadcast bus.
//   - Busy entries snoop CDB_* (arithmetic results) and LS_CDB_* (load
//     results) for their missing operands. LS_CDB wins a tag tie.
//   - The head entry issues on ALU_* once both operands are ready, ALU_enable
//     is high and no issue happened on the previous edge.
//   - ROB_roll_back_flag empties the queue. rdy=0 freezes all state.
// Ports: clk, rst (async, active high), rdy; DP_* dispatch in; LSB_is_full
// out; CDB_* / LS_CDB_* broadcast in; ALU_enable in; ALU_* issue out;
// ROB_roll_back_flag in.

// Operand capture for one operand slot. If the slot is not ready and its tag
// is on a bus, the slot takes that bus value; LS_CDB has priority.
module ls_buffer_snoop #(
  parameter int TAG_W = 4
) (
  input  logic             rdy_in,
  input  logic [31:0]      val_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             ls_valid,
  input  logic [TAG_W-1:0] ls_tag,
  input  logic [31:0]      ls_value,
  output logic             rdy_out,
  output logic [31:0]      val_out
);
  always_comb begin
    rdy_out = rdy_in;
    val_out = val_in;
    if (!rdy_in) begin
      if (ls_valid && ls_tag == tag_in) begin
        rdy_out = 1'b1;
        val_out = ls_value;
      end else if (cdb_valid && cdb_tag == tag_in) begin
        rdy_out = 1'b1;
        val_out = cdb_value;
      end
    end
  end
endmodule

module ls_buffer #(
  parameter int         LSB_SIZE = 16,
  parameter int         IDX_W    = 4,
  parameter logic [5:0] OP_SB    = 6'd16,
  parameter logic [5:0] OP_SH    = 6'd17,
  parameter logic [5:0] OP_SW    = 6'd18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        DP_valid,
  input  logic [5:0]  DP_OP_ID,
  input  logic [31:0] DP_inst_pc,
  input  logic        DP_rs1_ready,
  input  logic [31:0] DP_rs1_val,
  input  logic [3:0]  DP_rs1_tag,
  input  logic        DP_rs2_ready,
  input  logic [31:0] DP_rs2_val,
  input  logic [3:0]  DP_rs2_tag,
  input  logic [31:0] DP_imm,
  input  logic [3:0]  DP_ROB_id,
  output logic        LSB_is_full,
  input  logic        CDB_valid,
  input  logic [3:0]  CDB_ROB_id,
  input  logic [31:0] CDB_value,
  input  logic        LS_CDB_valid,
  input  logic [3:0]  LS_CDB_ROB_id,
  input  logic [31:0] LS_CDB_value,
  input  logic        ALU_enable,
  output logic        ALU_output_valid,
  output logic [5:0]  ALU_OP_ID,
  output logic [31:0] ALU_inst_pc,
  output logic [31:0] ALU_reg_rs1,
  output logic [31:0] ALU_reg_rs2,
  output logic [31:0] ALU_imm,
  output logic [3:0]  ALU_ROB_id,
  input  logic        ROB_roll_back_flag
);
  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W+1)'(LSB_SIZE);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(LSB_SIZE-1);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [LSB_SIZE-1:0]            busy, q1_rdy, q2_rdy;
  logic [LSB_SIZE-1:0][5:0]       op;
  logic [LSB_SIZE-1:0][31:0]      pc, imm, v1, v2;
  logic [LSB_SIZE-1:0][3:0]       rob_id, t1, t2;
  logic [IDX_W-1:0]               head, tail;
  logic [IDX_W:0]                 count;

  // post-snoop operand state per entry
  logic [LSB_SIZE-1:0]            s1_rdy, s2_rdy;
  logic [LSB_SIZE-1:0][31:0]      s1_val, s2_val;

  for (genvar i = 0; i < LSB_SIZE; i++) begin : g_ent
    ls_buffer_snoop u_q1 (
      .rdy_in(q1_rdy[i]), .val_in(v1[i]), .tag_in(t1[i]),
      .cdb_valid(CDB_valid), .cdb_tag(CDB_ROB_id), .cdb_value(CDB_value),
      .ls_valid(LS_CDB_valid), .ls_tag(LS_CDB_ROB_id), .ls_value(LS_CDB_value),
      .rdy_out(s1_rdy[i]), .val_out(s1_val[i]));
    ls_buffer_snoop u_q2 (
      .rdy_in(q2_rdy[i]), .val_in(v2[i]), .tag_in(t2[i]),
      .cdb_valid(CDB_valid), .cdb_tag(CDB_ROB_id), .cdb_value(CDB_value),
      .ls_valid(LS_CDB_valid), .ls_tag(LS_CDB_ROB_id), .ls_value(LS_CDB_value),
      .rdy_out(s2_rdy[i]), .val_out(s2_val[i]));
  end

  // same-cycle bypass for the dispatched operands
  logic        d1_rdy, d2_rdy;
  logic [31:0] d1_val, d2_val;

  ls_buffer_snoop u_dp1 (
    .rdy_in(DP_rs1_ready), .val_in(DP_rs1_val), .tag_in(DP_rs1_tag),
    .cdb_valid(CDB_valid), .cdb_tag(CDB_ROB_id), .cdb_value(CDB_value),
    .ls_valid(LS_CDB_valid), .ls_tag(LS_CDB_ROB_id), .ls_value(LS_CDB_value),
    .rdy_out(d1_rdy), .val_out(d1_val));
  ls_buffer_snoop u_dp2 (
    .rdy_in(DP_rs2_ready), .val_in(DP_rs2_val), .tag_in(DP_rs2_tag),
    .cdb_valid(CDB_valid), .cdb_tag(CDB_ROB_id), .cdb_value(CDB_value),
    .ls_valid(LS_CDB_valid), .ls_tag(LS_CDB_ROB_id), .ls_value(LS_CDB_value),
    .rdy_out(d2_rdy), .val_out(d2_val));

  logic dp_store, dp_fire, iss_fire;

  assign dp_store = (DP_OP_ID == OP_SB) || (DP_OP_ID == OP_SH) || (DP_OP_ID == OP_SW);
  assign dp_fire  = DP_valid && (count != CNT_MAX);
  // Issue looks at registered state only; the !ALU_output_valid term
  // covers alu_ls's enable lagging one cycle behind an accepted issue.
  assign iss_fire = busy[head] && q1_rdy[head] && q2_rdy[head] &&
                    ALU_enable && !ALU_output_valid;

  assign LSB_is_full = (count >= CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy             <= '0;
      q1_rdy           <= '0;
      q2_rdy           <= '0;
      op               <= '0;
      pc               <= '0;
      imm              <= '0;
      v1               <= '0;
      v2               <= '0;
      rob_id           <= '0;
      t1               <= '0;
      t2               <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ALU_output_valid <= 1'b0;
      ALU_OP_ID        <= '0;
      ALU_inst_pc      <= '0;
      ALU_reg_rs1      <= '0;
      ALU_reg_rs2      <= '0;
      ALU_imm          <= '0;
      ALU_ROB_id       <= '0;
    end else if (rdy) begin
      if (ROB_roll_back_flag) begin
        busy             <= '0;
        head             <= '0;
        tail             <= '0;
        count            <= '0;
        ALU_output_valid <= 1'b0;
      end else begin
        for (int i = 0; i < LSB_SIZE; i++) begin
          if (busy[i]) begin
            q1_rdy[i] <= s1_rdy[i];
            v1[i]     <= s1_val[i];
            q2_rdy[i] <= s2_rdy[i];
            v2[i]     <= s2_val[i];
          end
        end

        ALU_output_valid <= iss_fire;
        if (iss_fire) begin
          ALU_OP_ID   <= op[head];
          ALU_inst_pc <= pc[head];
          ALU_reg_rs1 <= v1[head];
          ALU_reg_rs2 <= v2[head];
          ALU_imm     <= imm[head];
          ALU_ROB_id  <= rob_id[head];
          busy[head]  <= 1'b0;
          head        <= head + IDX_ONE;
        end

        // tail slot is never busy while dispatch is allowed, so this cannot
        // collide with the snoop update or the issue clear above
        if (dp_fire) begin
          busy[tail]   <= 1'b1;
          op[tail]     <= DP_OP_ID;
          pc[tail]     <= DP_inst_pc;
          imm[tail]    <= DP_imm;
          rob_id[tail] <= DP_ROB_id;
          q1_rdy[tail] <= d1_rdy;
          v1[tail]     <= d1_val;
          t1[tail]     <= DP_rs1_tag;
          // loads have no store data; mark it resolved
          q2_rdy[tail] <= dp_store ? d2_rdy : 1'b1;
          v2[tail]     <= d2_val;
          t2[tail]     <= DP_rs2_tag;
          tail         <= tail + IDX_ONE;
        end

        if (dp_fire && !iss_fire)      count <= count + CNT_ONE;
        else if (!dp_fire && iss_fire) count <= count - CNT_ONE;
      end
    end
  end
endmodule
